data_sram_responder: RTL and testbench

- Data-side slave for the CPU's SRAM-like data interface. Answers the req/addr_ok/data_ok handshake that the EXE stage issues and the MEM stage completes.
- Holds a synchronous word-addressed backing store and a small in-order queue of outstanding requests. Returns data_ok (plus rdata for loads) a fixed number of cycles after each address handshake.
- Used as the data memory in simulation and small FPGA builds, and as the bench model for the MEM stage's data_ok wait logic.

---
 rtl/data_sram_responder.sv | 99 +++++++++
 tb/tb_data_sram_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data-side SRAM-like slave: word-addressed backing store plus an in-order
// queue that answers each accepted request with data_ok a fixed latency later.
module data_sram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1,
  parameter int DEPTH      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WORDS = 1 << ADDR_WIDTH;
  localparam logic [3:0]       LAT  = 4'(LATENCY);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]           mem [WORDS];
  logic [DEPTH-1:0]      q_valid;
  logic [DEPTH-1:0]      q_load;
  logic [31:0]           q_data [DEPTH];
  logic [3:0]            q_age  [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] word;
  logic                  accept;
  logic                  retire;
  logic                  unused_bits;

  assign word   = data_sram_addr[ADDR_WIDTH+1:2];
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_WIDTH+2],
                         data_sram_addr[1:0]};

  // No bypass from a same-cycle retire: a full queue refuses until it has popped.
  assign data_sram_addr_ok = !reset && (count < FULL);
  assign accept = data_sram_req && data_sram_addr_ok;
  assign retire = !reset && q_valid[rd_ptr] && (q_age[rd_ptr] == LAT);

  assign data_sram_data_ok = retire;
  assign data_sram_rdata   = (retire && q_load[rd_ptr]) ? q_data[rd_ptr] : 32'h0;

  // Backing store survives reset so preloaded contents stay usable.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) begin
          mem[word][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Ages tick once per cycle including the acceptance cycle, so a new entry
  // lands with age 1 and a LATENCY of 1 answers in the very next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_valid[i] && (q_age[i] != LAT)) begin
          q_age[i] <= q_age[i] + 4'd1;
        end
      end
      if (retire) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PTR_W'(1);
      end
      if (accept) begin
        q_valid[wr_ptr] <= 1'b1;
        q_load[wr_ptr]  <= !data_sram_wr;
        q_data[wr_ptr]  <= data_sram_wr ? 32'h0 : mem[word];
        q_age[wr_ptr]   <= 4'd1;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      case ({accept, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (LATENCY 1, 8, 4) driven by
// directed steps, with a scoreboard of expected data_ok beats per instance.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic [2:0]  reset_v;
  logic [2:0]  req_v;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok_v [3];
  logic        data_ok_v [3];
  logic [31:0] rdata_v   [3];

  typedef struct {
    int          inst;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb [$];
  int          cyc = 0;
  int          last_due [3] = '{default: 0};
  logic [31:0] mdl [3][1024];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_sram_responder #(
      .ADDR_WIDTH(10),
      .LATENCY   (g == 0 ? 1 : (g == 1 ? 8 : 4)),
      .DEPTH     (4)
    ) dut (
      .clk              (clk),
      .reset            (reset_v[g]),
      .data_sram_req    (req_v[g]),
      .data_sram_wr     (wr),
      .data_sram_size   (size),
      .data_sram_wstrb  (wstrb),
      .data_sram_addr   (addr),
      .data_sram_wdata  (wdata),
      .data_sram_addr_ok(addr_ok_v[g]),
      .data_sram_data_ok(data_ok_v[g]),
      .data_sram_rdata  (rdata_v[g])
    );
  end

  function automatic int lat_of(int inst);
    return (inst == 0) ? 1 : ((inst == 1) ? 8 : 4);
  endfunction

  function automatic int find_exp(int inst);
    for (int j = 0; j < sb.size(); j++) begin
      if (sb[j].inst == inst) return j;
    end
    return -1;
  endfunction

  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Every negedge: match data_ok beats against the scoreboard, flag missing ones.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int k;
      k = find_exp(i);
      if (data_ok_v[i] === 1'b1) begin
        if (k < 0) begin
          check_output("unexpected_data_ok", 32'(data_ok_v[i]), 32'h0);
        end else begin
          check_output("rdata", rdata_v[i], sb[k].data);
          check_output("data_ok_cycle", 32'(cyc), 32'(sb[k].due));
          sb.delete(k);
        end
      end else begin
        check_output("idle_data_ok", 32'(data_ok_v[i]), 32'h0);
        check_output("idle_rdata", rdata_v[i], 32'h0);
        if (k >= 0 && sb[k].due <= cyc) begin
          check_output("missing_data_ok", 32'(data_ok_v[i]), 32'h1);
          sb.delete(k);
        end
      end
    end
  end

  task automatic apply_stimulus(input int inst, input bit is_wr, input logic [3:0] strb,
                                input logic [31:0] a, input logic [31:0] d,
                                output int acc_cyc);
    int          waited;
    int          due;
    logic [9:0]  idx;
    logic [31:0] exp_data;
    waited = 0;
    @(negedge clk);
    wr = is_wr; wstrb = strb; addr = a; wdata = d; size = 2'd2;
    req_v = '0;
    req_v[inst] = 1'b1;
    while (addr_ok_v[inst] !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (addr_ok_v[inst] !== 1'b1) begin
      check_output("accept_timeout", 32'(addr_ok_v[inst]), 32'h1);
      acc_cyc = -1;
      return;
    end
    acc_cyc = cyc;
    idx = a[11:2];
    exp_data = 32'h0;
    if (is_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mdl[inst][idx][8*b +: 8] = d[8*b +: 8];
      end
    end else begin
      exp_data = mdl[inst][idx];
    end
    due = cyc + lat_of(inst);
    if (last_due[inst] + 1 > due) due = last_due[inst] + 1;
    last_due[inst] = due;
    sb.push_back('{inst: inst, data: exp_data, due: due});
  endtask

  task automatic wait_drain(input int inst);
    int w;
    w = 0;
    @(negedge clk);
    req_v = '0;
    while (find_exp(inst) >= 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_output("drain_pending", 32'(find_exp(inst) + 1), 32'h0);
  endtask

  initial begin
    int t;
    int acc [6];
    int gaps [6] = '{0, 1, 2, 3, 9, 10};
    reset_v = 3'b111; req_v = '0; wr = 1'b0; size = 2'd2;
    wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    check_output("reset_addr_ok", 32'(addr_ok_v[0]), 32'h0);
    reset_v = 3'b000;
    #1;
    check_output("post_reset_addr_ok", 32'(addr_ok_v[0]), 32'h1);

    // LATENCY 1: preload then load word 4
    apply_stimulus(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, t);
    wait_drain(0);
    apply_stimulus(0, 1'b0, 4'h0, 32'h10, 32'h0, t);
    wait_drain(0);

    // Store immediately followed by a load of the same word
    apply_stimulus(0, 1'b1, 4'hF, 32'h20, 32'h11223344, t);
    apply_stimulus(0, 1'b0, 4'h0, 32'h20, 32'h0, t);
    wait_drain(0);

    // Single-lane store merges into the existing word
    apply_stimulus(0, 1'b1, 4'hF, 32'h20, 32'hAABBCCDD, t);
    apply_stimulus(0, 1'b1, 4'b0100, 32'h22, 32'h00EE0000, t);
    apply_stimulus(0, 1'b0, 4'h0, 32'h20, 32'h0, t);
    wait_drain(0);

    // Aliasing on high/low address bits, and a store with no lanes enabled
    apply_stimulus(0, 1'b1, 4'hF, 32'h00001004, 32'hCAFEF00D, t);
    apply_stimulus(0, 1'b0, 4'h0, 32'h80001004, 32'h0, t);
    apply_stimulus(0, 1'b1, 4'h0, 32'h00001004, 32'hFFFFFFFF, t);
    apply_stimulus(0, 1'b0, 4'h0, 32'h00001007, 32'h0, t);
    wait_drain(0);

    // LATENCY 8, DEPTH 4: fill the queue and check when addr_ok reopens
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(1, 1'b1, 4'hF, 32'(k * 4), 32'hA5000000 + 32'(k), t);
    end
    wait_drain(1);
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(1, 1'b0, 4'h0, 32'(k * 4), 32'h0, acc[k]);
    end
    wait_drain(1);
    for (int k = 1; k < 6; k++) begin
      check_output($sformatf("accept_gap_%0d", k), 32'(acc[k] - acc[0]), 32'(gaps[k]));
    end

    // LATENCY 4: reset with two loads in flight discards them
    apply_stimulus(2, 1'b1, 4'hF, 32'h40, 32'h12345678, t);
    apply_stimulus(2, 1'b1, 4'hF, 32'h44, 32'h9ABCDEF0, t);
    wait_drain(2);
    apply_stimulus(2, 1'b0, 4'h0, 32'h40, 32'h0, t);
    apply_stimulus(2, 1'b0, 4'h0, 32'h44, 32'h0, t);
    @(negedge clk);
    req_v = '0;
    reset_v[2] = 1'b1;
    #1;
    check_output("mid_reset_addr_ok", 32'(addr_ok_v[2]), 32'h0);
    check_output("mid_reset_data_ok", 32'(data_ok_v[2]), 32'h0);
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].inst == 2) sb.delete(j);
    end
    last_due[2] = 0;
    @(negedge clk);
    reset_v[2] = 1'b0;
    repeat (8) @(negedge clk);
    apply_stimulus(2, 1'b0, 4'h0, 32'h44, 32'h0, t);
    wait_drain(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
